// File: rtl/rbr_decoder.sv
// Level-code to thermometer reference decoder: drives the decoded pattern for
// HOLD_CYC cycles, samples the comparator outputs, then reports completion.
module rbr_decoder #(
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       code_valid_i,
   input  logic [3:0] code_i,
   output logic       code_ready_o,
   output logic [7:0] ref_o,
   output logic       ref_en_o,
   input  logic [7:0] sense_i,
   output logic       done_o,
   output logic       match_o,
   output logic       err_o,
   output logic [1:0] state_o
);

   // Handshake: a code transfers on a rising edge where code_valid_i and
   // code_ready_o are both high; the requester holds code_i until then.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYC - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] dec_pat;
   logic       dec_legal;

   always_comb begin
      dec_pat   = 8'h00;
      dec_legal = 1'b1;
      case (code_i)
         4'd0:    dec_pat = 8'hFF;
         4'd1:    dec_pat = 8'hFE;
         4'd2:    dec_pat = 8'hFC;
         4'd3:    dec_pat = 8'hF8;
         4'd4:    dec_pat = 8'hF0;
         4'd6:    dec_pat = 8'hE0;
         4'd9:    dec_pat = 8'h00;
         default: dec_legal = 1'b0;
      endcase
   end

   assign state_o = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         code_ready_o <= 1'b0;
         ref_o        <= 8'h00;
         ref_en_o     <= 1'b0;
         done_o       <= 1'b0;
         match_o      <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               // Ready rises one edge after reset release and stays up in IDLE.
               code_ready_o <= 1'b1;
               if (code_valid_i && code_ready_o) begin
                  if (dec_legal) begin
                     state        <= DRIVE;
                     cnt          <= LOAD_VAL;
                     ref_o        <= dec_pat;
                     ref_en_o     <= 1'b1;
                     code_ready_o <= 1'b0;
                  end else begin
                     err_o   <= 1'b1;
                     match_o <= 1'b0;
                  end
               end
            end
            DRIVE: begin
               code_ready_o <= 1'b0;
               if (cnt == 8'd0) begin
                  match_o  <= (sense_i == ref_o);
                  done_o   <= 1'b1;
                  ref_o    <= 8'h00;
                  ref_en_o <= 1'b0;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               code_ready_o <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state        <= IDLE;
               code_ready_o <= 1'b0;
               ref_o        <= 8'h00;
               ref_en_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rbr_decoder.md
RBR_DECODER -- requirements
Module: rbr_decoder

Interface
REQ-001 Parameter HOLD_CYC, default 4, number of cycles the reference pattern is driven before sampling; legal range 1..255.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous assertion, active-high.
REQ-004 code_valid_i  input  1  requester presents a level code.
REQ-005 code_i  input  4  level code to decode.
REQ-006 code_ready_o  output  1  block can accept a code this cycle.
REQ-007 ref_o  output  8  thermometer reference pattern to the analog array.
REQ-008 ref_en_o  output  1  ref_o is being actively driven.
REQ-009 sense_i  input  8  comparator outputs returned from the array.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 match_o  output  1  valid with done_o; sampled sense_i equals driven pattern.
REQ-012 err_o  output  1  one-cycle pulse; accepted code was illegal.

Function
REQ-013 Decode table: 0->8'hFF, 1->8'hFE, 2->8'hFC, 3->8'hF8, 4->8'hF0, 6->8'hE0, 9->8'h00.
REQ-014 Codes 5, 7, 8, 10..15 are illegal.
REQ-015 States: IDLE, DRIVE, DONE.
REQ-016 IDLE: code_ready_o=1, ref_en_o=0, ref_o=8'h00.
REQ-017 A transfer occurs when code_valid_i and code_ready_o are both 1 on a rising edge.
REQ-018 A legal code accepted in IDLE: decoded pattern registered into ref_o, ref_en_o=1, hold counter loaded with HOLD_CYC-1, next state DRIVE.
REQ-019 An illegal code accepted in IDLE: err_o=1 for exactly the next cycle, ref_en_o stays 0, no done_o, state stays IDLE.
REQ-020 DRIVE: code_ready_o=0, ref_o and ref_en_o held stable; counter decrements by 1 each cycle.
REQ-021 DRIVE, counter=0: sense_i sampled, match_o <= (sense_i==ref_o), next state DONE.
REQ-022 DONE lasts one cycle: done_o=1, match_o valid, ref_en_o=0, ref_o=8'h00, code_ready_o=0.
REQ-023 After DONE, return to IDLE.
REQ-024 Latency: done_o asserts HOLD_CYC+1 cycles after the accepting edge; ref_en_o high for exactly HOLD_CYC cycles.
REQ-025 Back-to-back: minimum spacing between accepted codes is HOLD_CYC+2 cycles (IDLE must be re-entered).
REQ-026 code_valid_i while not ready: ignored, nothing latched; requester holds code_i until ready.
REQ-027 match_o holds its last value outside DONE.
REQ-028 match_o is cleared to 0 on an illegal-code acceptance.
REQ-029 sense_i is ignored in every cycle except the DRIVE sample cycle.
REQ-030 Counter width 8 bits; no wrap: counter only decrements from a nonzero value.

Reset
REQ-031 rst_i=1 immediately forces state IDLE and counter 0.
REQ-032 rst_i=1 immediately clears ref_o=8'h00 and ref_en_o, done_o, match_o, err_o to 0.
REQ-033 rst_i=1 forces code_ready_o=0.
REQ-034 code_ready_o goes to 1 on the first rising edge after rst_i deasserts.
REQ-035 Reset asserted during DRIVE or DONE aborts the operation: no done_o after release, ref_en_o drops without waiting for a clock.

Verification
REQ-036 HOLD_CYC=4, accept code 3, sense_i=8'hF8 -> ref_o=8'hF8 with ref_en_o=1 for 4 cycles; done_o 5 cycles after accept; match_o=1.
REQ-037 Accept code 9, sense_i=8'h80 -> ref_o=8'h00; done_o with match_o=0.
REQ-038 Sweep codes 0..15 with sense_i looped back from ref_o -> 0,1,2,3,4,6,9 give done_o with match_o=1; remaining codes give err_o one-cycle pulse, no ref_en_o, ready again next cycle.
REQ-039 code_valid_i held high continuously with code 2 -> accepts spaced exactly HOLD_CYC+2 cycles; ref_o never changes while ref_en_o=1.
REQ-040 Assert rst_i mid-DRIVE (cycle 2 of 4) -> ref_en_o=0 and ref_o=8'h00 asynchronously; no done_o; code_ready_o=1 one edge after release.
REQ-041 HOLD_CYC=1, accept code 0 -> ref_en_o high one cycle; done_o 2 cycles after accept.
